inst_mem_fetch: RTL and testbench

- Parametrised, clocked successor to the combinational instruction memory.
- Holds DEPTH words of program, loadable at run time through a write port instead of hard-wired contents.
- Serves fetch requests from the IF stage through a req/ready → valid/stall handshake with configurable read latency, branch flush, and address-fault reporting.
- Sits between the PC register and the IF/ID pipeline register.

---
 rtl/inst_mem_fetch_pkg.sv | 40 ++++
 rtl/inst_mem_fetch_if.sv | 39 +++
 rtl/inst_mem_fetch_array.sv | 36 +++
 rtl/inst_mem_fetch.sv | 152 +++++++++++++++
 tb/tb_inst_mem_fetch.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_mem_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_mem_fetch_pkg
//  Description : Shared constants, fault-reason encoding and address helpers
//                for the clocked instruction memory fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package inst_mem_fetch_pkg;

  // Word returned on any faulting fetch: MOV r0,r0
  localparam logic [31:0] NOP_INST = 32'hE1A00000;

  // Why a fetch or load address was rejected
  typedef enum logic [1:0] {
    FAULT_NONE  = 2'd0,
    FAULT_ALIGN = 2'd1,
    FAULT_RANGE = 2'd2
  } fault_e;

  // Byte address to word index; callers zero-extend to 64 bits so the
  // range compare never truncates the upper address bits.
  function automatic logic [63:0] word_index(input logic [63:0] addr);
    return addr >> 2;
  endfunction

  // Alignment is checked first so a misaligned out-of-range address
  // reports the alignment problem.
  function automatic fault_e fault_classify(input logic [63:0] addr,
                                            input logic [63:0] depth);
    if (addr[1:0] != 2'b00) begin
      return FAULT_ALIGN;
    end
    if (word_index(addr) >= depth) begin
      return FAULT_RANGE;
    end
    return FAULT_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_mem_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_mem_fetch_if
//  Description : Load port, fetch handshake and result bus between the IF
//                stage (master) and the instruction memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_mem_fetch_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();

  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_pc;
  logic              fetch_ready;
  logic              flush;
  logic              stall;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              addr_fault;

  modport master (
    output load_en, load_addr, load_data,
    output fetch_req, fetch_pc, flush, stall,
    input  fetch_ready, inst_valid, inst, inst_pc, addr_fault
  );

  modport slave (
    input  load_en, load_addr, load_data,
    input  fetch_req, fetch_pc, flush, stall,
    output fetch_ready, inst_valid, inst, inst_pc, addr_fault
  );

endinterface
`default_nettype wire

// File: rtl/inst_mem_fetch_array.sv
`default_nettype none
// ============================================================================
//  Module      : inst_mem_array
//  Description : DEPTH x DATA_W program store, synchronous write and
//                combinational read, no reset so contents survive rst_n.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam logic [IDX_W:0] c_depth_ext = (IDX_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  // Program write; the caller only asserts we for in-range word indices
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Unsized index space beyond DEPTH (non power-of-two) reads as zero
  assign rdata = ({1'b0, raddr} < c_depth_ext) ? mem[raddr] : '0;

endmodule
`default_nettype wire

// File: rtl/inst_mem_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : inst_mem_fetch
//  Description : Clocked, run-time loadable instruction memory with a
//                req/ready -> valid/stall fetch handshake, 1- or 2-cycle read
//                latency, branch flush and address-fault reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_fetch #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 64,
  parameter int                ADDR_W   = 32,
  parameter int                READ_LAT = 1,
  parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(inst_mem_fetch_pkg::NOP_INST)
) (
  input  logic               clk,
  input  logic               rst_n,
  inst_mem_fetch_if.slave    bus
);

  import inst_mem_fetch_pkg::*;

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if ((ADDR_W < IDX_W + 2) || (ADDR_W > 64)) begin : g_bad_addr_w
    $error("inst_mem_fetch: ADDR_W too small for DEPTH or wider than 64");
  end

  // --------------------------------------------------------------------------
  // Address decode and handshake
  // --------------------------------------------------------------------------
  fault_e            w_fetch_reason;
  fault_e            w_load_reason;
  logic              w_fetch_fault;
  logic              w_ready;
  logic              w_accept;
  logic              w_we;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_read_word;

  assign w_fetch_reason = fault_classify(64'(bus.fetch_pc), 64'(DEPTH));
  assign w_load_reason  = fault_classify(64'(bus.load_addr), 64'(DEPTH));
  assign w_fetch_fault  = (w_fetch_reason != FAULT_NONE);

  // A load owns the cycle; the pipeline still drains but takes nothing new
  assign w_ready  = !bus.load_en && !bus.stall;
  assign w_accept = bus.fetch_req && w_ready;

  // Faulting load addresses are dropped rather than aliased onto a word
  assign w_we = bus.load_en && (w_load_reason == FAULT_NONE);

  // Fault substitution happens at read time so both latencies share it
  assign w_read_word = w_fetch_fault ? NOP_INST : w_rdata;

  assign bus.fetch_ready = w_ready;

  inst_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (w_we),
    .waddr (bus.load_addr[IDX_W+1:2]),
    .wdata (bus.load_data),
    .raddr (bus.fetch_pc[IDX_W+1:2]),
    .rdata (w_rdata)
  );

  // --------------------------------------------------------------------------
  // Output stage registers (driven from exactly one latency branch)
  // --------------------------------------------------------------------------
  logic              r_out_valid;
  logic              r_out_fault;
  logic [ADDR_W-1:0] r_out_pc;
  logic [DATA_W-1:0] r_out_inst;

  assign bus.inst_valid = r_out_valid;
  assign bus.addr_fault = r_out_fault;
  assign bus.inst_pc    = r_out_pc;
  assign bus.inst       = r_out_inst;

  if (READ_LAT == 1) begin : g_lat1

    // Single stage: accepted request lands directly in the output registers.
    // Flush overrides stall; an accept (only possible when not stalled) is
    // the branch target and survives the flush.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_out_valid <= 1'b0;
        r_out_fault <= 1'b0;
        r_out_pc    <= '0;
        r_out_inst  <= '0;
      end else if (bus.flush || !bus.stall) begin
        r_out_valid <= w_accept;
        if (w_accept) begin
          r_out_fault <= w_fetch_fault;
          r_out_pc    <= bus.fetch_pc;
          r_out_inst  <= w_read_word;
        end
      end
    end

  end else if (READ_LAT == 2) begin : g_lat2

    logic              r_s1_valid;
    logic              r_s1_fault;
    logic [ADDR_W-1:0] r_s1_pc;
    logic [DATA_W-1:0] r_s1_inst;

    // Two stages: stage 1 captures pc, fault and the array read, stage 2 is
    // the output. Stall freezes both; flush empties both and lets only the
    // same-edge accept into stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1_valid  <= 1'b0;
        r_s1_fault  <= 1'b0;
        r_s1_pc     <= '0;
        r_s1_inst   <= '0;
        r_out_valid <= 1'b0;
        r_out_fault <= 1'b0;
        r_out_pc    <= '0;
        r_out_inst  <= '0;
      end else if (bus.flush || !bus.stall) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_fault <= w_fetch_fault;
          r_s1_pc    <= bus.fetch_pc;
          r_s1_inst  <= w_read_word;
        end
        if (bus.flush) begin
          r_out_valid <= 1'b0;
        end else begin
          r_out_valid <= r_s1_valid;
          if (r_s1_valid) begin
            r_out_fault <= r_s1_fault;
            r_out_pc    <= r_s1_pc;
            r_out_inst  <= r_s1_inst;
          end
        end
      end
    end

  end else begin : g_bad_lat
    $error("inst_mem_fetch: READ_LAT must be 1 or 2");
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_mem_fetch
//  Description : Directed self-checking bench; drives one stimulus stream
//                into a READ_LAT=1 and a READ_LAT=2 instance side by side.
//                Observed vector = {inst_valid, addr_fault, inst_pc, inst}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_mem_fetch;

  localparam logic [31:0] W0  = 32'hE3A00A01;
  localparam logic [31:0] W1  = 32'hE3A01015;
  localparam logic [31:0] W2  = 32'hE3A02003;
  localparam logic [31:0] W3  = 32'hE3A03004;
  localparam logic [31:0] W5  = 32'hE3A05006;
  localparam logic [31:0] W2N = 32'hE3A0200A;
  localparam logic [31:0] NOP = 32'hE1A00000;

  logic clk;
  logic rst_n;

  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        flush;
  logic        stall;

  int checks;
  int bad;
  logic [65:0] exp1;
  logic [65:0] exp2;
  logic [65:0] o1;
  logic [65:0] o2;

  inst_mem_fetch_if #(.DATA_W(32), .ADDR_W(32)) bus1 ();
  inst_mem_fetch_if #(.DATA_W(32), .ADDR_W(32)) bus2 ();

  assign bus1.load_en   = load_en;
  assign bus1.load_addr = load_addr;
  assign bus1.load_data = load_data;
  assign bus1.fetch_req = fetch_req;
  assign bus1.fetch_pc  = fetch_pc;
  assign bus1.flush     = flush;
  assign bus1.stall     = stall;
  assign bus2.load_en   = load_en;
  assign bus2.load_addr = load_addr;
  assign bus2.load_data = load_data;
  assign bus2.fetch_req = fetch_req;
  assign bus2.fetch_pc  = fetch_pc;
  assign bus2.flush     = flush;
  assign bus2.stall     = stall;

  assign o1 = {bus1.inst_valid, bus1.addr_fault, bus1.inst_pc, bus1.inst};
  assign o2 = {bus2.inst_valid, bus2.addr_fault, bus2.inst_pc, bus2.inst};

  inst_mem_fetch #(.READ_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  inst_mem_fetch #(.READ_LAT(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (o1 !== 66'h0) begin bad++; $display("FAIL rst_lat1 got=%h want=0", o1); end
    checks++;
    if (o2 !== 66'h0) begin bad++; $display("FAIL rst_lat2 got=%h want=0", o2); end
    checks++;
    if (bus1.fetch_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", bus1.fetch_ready); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_load_fetch();
    logic [31:0] addrs [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h14};
    logic [31:0] words [5] = '{W0, W1, W2, W3, W5};
    for (int i = 0; i < 5; i++) begin
      load_en = 1'b1; load_addr = addrs[i]; load_data = words[i];
      step();
    end
    load_en = 1'b0;
    fetch_req = 1'b1; fetch_pc = 32'h0;
    step();
    exp1 = {2'b10, 32'h0, W0}; exp2 = 66'h0;
    checks++; if (o1 !== exp1) begin bad++; $display("FAIL lf_e1_lat1 got=%h want=%h", o1, exp1); end
    checks++; if (o2 !== exp2) begin bad++; $display("FAIL lf_e1_lat2 got=%h want=%h", o2, exp2); end
    fetch_pc = 32'h4;
    step();
    exp1 = {2'b10, 32'h4, W1}; exp2 = {2'b10, 32'h0, W0};
    checks++; if (o1 !== exp1) begin bad++; $display("FAIL lf_e2_lat1 got=%h want=%h", o1, exp1); end
    checks++; if (o2 !== exp2) begin bad++; $display("FAIL lf_e2_lat2 got=%h want=%h", o2, exp2); end
    fetch_req = 1'b0;
    step();
    exp1 = {2'b00, 32'h4, W1}; exp2 = {2'b10, 32'h4, W1};
    checks++; if (o1 !== exp1) begin bad++; $display("FAIL lf_e3_lat1 got=%h want=%h", o1, exp1); end
    checks++; if (o2 !== exp2) begin bad++; $display("FAIL lf_e3_lat2 got=%h want=%h", o2, exp2); end
    step();
    exp2 = {2'b00, 32'h4, W1};
    checks++; if (o2 !== exp2) begin bad++; $display("FAIL lf_e4_lat2 got=%h want=%h", o2, exp2); end
  endtask

  task automatic test_faults();
    fetch_req = 1'b1; fetch_pc = 32'h102;
    step();
    exp1 = {2'b11, 32'h102, NOP};
    checks++; if (o1 !== exp1) begin bad++; $display("FAIL flt_mis_lat1 got=%h want=%h", o1, exp1); end
    fetch_pc = 32'h100;
    step();
    exp1 = {2'b11, 32'h100, NOP}; exp2 = {2'b11, 32'h102, NOP};
    checks++; if (o1 !== exp1) begin bad++; $display("FAIL flt_rng_lat1 got=%h want=%h", o1, exp1); end
    checks++; if (o2 !== exp2) begin bad++; $display("FAIL flt_mis_lat2 got=%h want=%h", o2, exp2); end
    fetch_pc = 32'h4000_0000;
    step();
    exp1 = {2'b11, 32'h4000_0000, NOP}; exp2 = {2'b11, 32'h100, NOP};
    checks++; if (o1 !== exp1) begin bad++; $display("FAIL flt_big_lat1 got=%h want=%h", o1, exp1); end
    checks++; if (o2 !== exp2) begin bad++; $display("FAIL flt_rng_lat2 got=%h want=%h", o2, exp2); end
    fetch_req = 1'b0;
    step();
    exp2 = {2'b11, 32'h4000_0000, NOP};
    checks++; if (o2 !== exp2) begin bad++; $display("FAIL flt_big_lat2 got=%h want=%h", o2, exp2); end
    // Faulting loads whose low index bits alias word 0 must not write it
    load_en = 1'b1; load_data = 32'hDEADBEEF;
    load_addr = 32'h100;       step();
    load_addr = 32'h2;         step();
    load_addr = 32'h4000_0000; step();
    load_en = 1'b0;
    fetch_req = 1'b1; fetch_pc = 32'h0;
    step();
    exp1 = {2'b10, 32'h0, W0};
    checks++; if (o1 !== exp1) begin bad++; $display("FAIL flt_load_ignored got=%h want=%h", o1, exp1); end
    fetch_req = 1'b0;
    step();
    step();
  endtask

  task automatic test_stall();
    fetch_req = 1'b1; fetch_pc = 32'h0;
    step();
    fetch_pc = 32'h4;
    step();
    stall = 1'b1; fetch_pc = 32'h8;
    #1;
    checks++; if (bus1.fetch_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b want=0", bus1.fetch_ready); end
    exp1 = {2'b10, 32'h4, W1}; exp2 = {2'b10, 32'h0, W0};
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (o1 !== exp1) begin bad++; $display("FAIL stall_hold%0d_lat1 got=%h want=%h", i, o1, exp1); end
      checks++; if (o2 !== exp2) begin bad++; $display("FAIL stall_hold%0d_lat2 got=%h want=%h", i, o2, exp2); end
    end
    stall = 1'b0;
    step();
    exp1 = {2'b10, 32'h8, W2}; exp2 = {2'b10, 32'h4, W1};
    checks++; if (o1 !== exp1) begin bad++; $display("FAIL stall_rel_lat1 got=%h want=%h", o1, exp1); end
    checks++; if (o2 !== exp2) begin bad++; $display("FAIL stall_rel_lat2 got=%h want=%h", o2, exp2); end
    fetch_req = 1'b0;
    step();
    exp1 = {2'b00, 32'h8, W2}; exp2 = {2'b10, 32'h8, W2};
    checks++; if (o1 !== exp1) begin bad++; $display("FAIL stall_nodup_lat1 got=%h want=%h", o1, exp1); end
    checks++; if (o2 !== exp2) begin bad++; $display("FAIL stall_last_lat2 got=%h want=%h", o2, exp2); end
    step();
    exp2 = {2'b00, 32'h8, W2};
    checks++; if (o2 !== exp2) begin bad++; $display("FAIL stall_nodup_lat2 got=%h want=%h", o2, exp2); end
  endtask

  task automatic test_flush();
    fetch_req = 1'b1; fetch_pc = 32'h0;
    step();
    fetch_pc = 32'h4;
    step();
    flush = 1'b1; fetch_pc = 32'h14;
    step();
    exp1 = {2'b10, 32'h14, W5}; exp2 = {2'b00, 32'h0, W0};
    checks++; if (o1 !== exp1) begin bad++; $display("FAIL fl_tgt_lat1 got=%h want=%h", o1, exp1); end
    checks++; if (o2 !== exp2) begin bad++; $display("FAIL fl_clr_lat2 got=%h want=%h", o2, exp2); end
    flush = 1'b0; fetch_req = 1'b0;
    step();
    exp1 = {2'b00, 32'h14, W5}; exp2 = {2'b10, 32'h14, W5};
    checks++; if (o1 !== exp1) begin bad++; $display("FAIL fl_idle_lat1 got=%h want=%h", o1, exp1); end
    checks++; if (o2 !== exp2) begin bad++; $display("FAIL fl_tgt_lat2 got=%h want=%h", o2, exp2); end
    step();
    // Flush while stalled still clears valid bits
    fetch_req = 1'b1; fetch_pc = 32'h8;
    step();
    stall = 1'b1; flush = 1'b1; fetch_req = 1'b0;
    step();
    exp1 = {2'b00, 32'h8, W2};
    checks++; if (o1 !== exp1) begin bad++; $display("FAIL fl_stall_lat1 got=%h want=%h", o1, exp1); end
    stall = 1'b0; flush = 1'b0;
    step();
    exp2 = {2'b00, 32'h14, W5};
    checks++; if (o2 !== exp2) begin bad++; $display("FAIL fl_stall_lat2 got=%h want=%h", o2, exp2); end
  endtask

  task automatic test_load_priority();
    fetch_req = 1'b1; fetch_pc = 32'h8;
    step();
    load_en = 1'b1; load_addr = 32'h8; load_data = W2N;
    #1;
    checks++; if (bus2.fetch_ready !== 1'b0) begin bad++; $display("FAIL lp_ready got=%b want=0", bus2.fetch_ready); end
    step();
    exp1 = {2'b00, 32'h8, W2}; exp2 = {2'b10, 32'h8, W2};
    checks++; if (o1 !== exp1) begin bad++; $display("FAIL lp_noacc_lat1 got=%h want=%h", o1, exp1); end
    checks++; if (o2 !== exp2) begin bad++; $display("FAIL lp_old_lat2 got=%h want=%h", o2, exp2); end
    load_en = 1'b0;
    step();
    exp1 = {2'b10, 32'h8, W2N}; exp2 = {2'b00, 32'h8, W2};
    checks++; if (o1 !== exp1) begin bad++; $display("FAIL lp_new_lat1 got=%h want=%h", o1, exp1); end
    checks++; if (o2 !== exp2) begin bad++; $display("FAIL lp_noacc_lat2 got=%h want=%h", o2, exp2); end
    fetch_req = 1'b0;
    step();
    exp2 = {2'b10, 32'h8, W2N};
    checks++; if (o2 !== exp2) begin bad++; $display("FAIL lp_new_lat2 got=%h want=%h", o2, exp2); end
  endtask

  task automatic test_reset_mid();
    fetch_req = 1'b1; fetch_pc = 32'h0;
    step();
    fetch_pc = 32'h4;
    step();
    fetch_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o1 !== 66'h0) begin bad++; $display("FAIL rm_async_lat1 got=%h want=0", o1); end
    checks++; if (o2 !== 66'h0) begin bad++; $display("FAIL rm_async_lat2 got=%h want=0", o2); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (o2 !== 66'h0) begin bad++; $display("FAIL rm_drop_lat2 got=%h want=0", o2); end
    fetch_req = 1'b1; fetch_pc = 32'h4;
    step();
    exp1 = {2'b10, 32'h4, W1};
    checks++; if (o1 !== exp1) begin bad++; $display("FAIL rm_read_lat1 got=%h want=%h", o1, exp1); end
    checks++; if (o2 !== 66'h0) begin bad++; $display("FAIL rm_early_lat2 got=%h want=0", o2); end
    fetch_req = 1'b0;
    step();
    exp2 = {2'b10, 32'h4, W1};
    checks++; if (o2 !== exp2) begin bad++; $display("FAIL rm_read_lat2 got=%h want=%h", o2, exp2); end
  endtask

  initial begin
    checks = 0; bad = 0;
    rst_n = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    fetch_req = 1'b0; fetch_pc = '0; flush = 1'b0; stall = 1'b0;
    test_reset();
    test_load_fetch();
    test_faults();
    test_stall();
    test_flush();
    test_load_priority();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end

endmodule
`default_nettype wire
